// File: rtl/ripple_carry_b_bit.sv
// B-bit ripple-carry adder with a registered sum, carry-out and group propagate.
// Define RIPPLE_OVF_EN to add a registered two's-complement overflow output (ovf).
module ripple_carry_b_bit #(
  parameter int B = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [B-1:0] a,
  input  logic [B-1:0] b,
  input  logic         cin,
  output logic [B-1:0] sum,
  output logic         cout,
  output logic         p,
`ifdef RIPPLE_OVF_EN
  output logic         ovf,
`endif
  output logic         out_valid
);

  logic [B-1:0] w_prop;
  logic [B-1:0] w_gen;
  logic [B-1:0] w_sum;
  logic [B:0]   w_c;
  logic         w_p;

  assign w_c[0] = cin;

  for (genvar i = 0; i < B; i++) begin : g_fa
    assign w_prop[i]  = a[i] ^ b[i];
    assign w_gen[i]   = a[i] & b[i];
    assign w_sum[i]   = w_prop[i] ^ w_c[i];
    assign w_c[i+1]   = w_gen[i] | (w_prop[i] & w_c[i]);
  end

  assign w_p = &w_prop;

  logic [B-1:0] r_sum;
  logic         r_cout;
  logic         r_p;
  logic         r_valid;

  // Data registers hold across idle cycles; only the valid flag follows in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_p     <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_c[B];
        r_p    <= w_p;
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign p         = r_p;
  assign out_valid = r_valid;

`ifdef RIPPLE_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_c[B] ^ w_c[B-1];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_ripple_carry_b_bit.sv
// Bench for ripple_carry_b_bit: arithmetic reference model checked every cycle
// plus hand-computed directed vectors.
module tb_ripple_carry_b_bit;

  localparam int B = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [B-1:0] a = '0;
  logic [B-1:0] b = '0;
  logic         cin = 1'b0;
  logic [B-1:0] sum;
  logic         cout;
  logic         p;
  logic         out_valid;
`ifdef RIPPLE_OVF_EN
  logic         ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  ripple_carry_b_bit #(.B(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .p         (p),
`ifdef RIPPLE_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  // Reference model: plain integer arithmetic on the captured operands.
  logic [B-1:0] m_sum;
  logic         m_cout;
  logic         m_p;
  logic         m_ovf;
  logic         m_valid;

  always @(posedge clk or posedge rst) begin : model
    int t, sa, sb, st, half;
    if (rst) begin
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_p     <= 1'b0;
      m_ovf   <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        half = 1 << (B - 1);
        t  = int'(a) + int'(b) + int'(cin);
        sa = (int'(a) >= half) ? int'(a) - 2 * half : int'(a);
        sb = (int'(b) >= half) ? int'(b) - 2 * half : int'(b);
        st = sa + sb + int'(cin);
        m_sum  <= B'(t % (1 << B));
        m_cout <= (t >= (1 << B));
        m_p    <= (a == ~b);
        m_ovf  <= (st >= half) || (st < -half);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("model_valid", 32'(out_valid), 32'(m_valid));
      check("model_sum", 32'(sum), 32'(m_sum));
      check("model_cout", 32'(cout), 32'(m_cout));
      check("model_p", 32'(p), 32'(m_p));
`ifdef RIPPLE_OVF_EN
      check("model_ovf", 32'(ovf), 32'(m_ovf));
`endif
    end
  end

  // Entered at posedge+2; drives inputs and returns at the next posedge+2.
  task automatic cyc(input logic v, input logic [B-1:0] ia,
                     input logic [B-1:0] ib, input logic ic);
    in_valid = v;
    a = ia;
    b = ib;
    cin = ic;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input logic [B-1:0] es,
                            input logic ec, input logic ep, input logic ev);
    check({name, "_sum"}, 32'(sum), 32'(es));
    check({name, "_cout"}, 32'(cout), 32'(ec));
    check({name, "_p"}, 32'(p), 32'(ep));
    check({name, "_valid"}, 32'(out_valid), 32'(ev));
  endtask

  initial begin
    in_valid = 1'b1;
    a = 4'd5;
    b = 4'd7;
    cin = 1'b1;
    #1;
    rst = 1'b1;
    started = 1'b1;
    #1;
    expect_out("async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
`ifdef RIPPLE_OVF_EN
    check("async_rst_ovf", 32'(ovf), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #2;
    expect_out("rst_hold", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    cyc(1'b1, 4'd9, 4'd6, 1'b0);
    expect_out("v9_6", 4'd15, 1'b0, 1'b1, 1'b1);

    cyc(1'b1, 4'd10, 4'd9, 1'b1);
    expect_out("v10_9", 4'd4, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 4'd13, 4'd12, 1'b1);
    expect_out("v13_12", 4'd10, 1'b1, 1'b0, 1'b1);

    cyc(1'b1, 4'd13, 4'd10, 1'b1);
    expect_out("v13_10", 4'd8, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 4'd3, 4'd3, 1'b0);
    expect_out("hold", 4'd8, 1'b1, 1'b0, 1'b0);

    cyc(1'b1, 4'd15, 4'd0, 1'b1);
    expect_out("ripple", 4'd0, 1'b1, 1'b1, 1'b1);

    cyc(1'b1, 4'd7, 4'd1, 1'b0);
    expect_out("v7_1", 4'd8, 1'b0, 1'b0, 1'b1);
`ifdef RIPPLE_OVF_EN
    check("v7_1_ovf", 32'(ovf), 32'd1);
`endif
    cyc(1'b1, 4'd8, 4'd8, 1'b0);
    expect_out("v8_8", 4'd0, 1'b1, 1'b0, 1'b1);
`ifdef RIPPLE_OVF_EN
    check("v8_8_ovf", 32'(ovf), 32'd1);
`endif

    // Reset arrives while a valid input waits for its capture edge.
    in_valid = 1'b1;
    a = 4'd3;
    b = 4'd4;
    cin = 1'b0;
    #4;
    rst = 1'b1;
    #1;
    expect_out("mid_rst", 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    expect_out("mid_rst_edge", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 4'd3, 4'd4, 1'b0);
    expect_out("post_rst_idle", 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd3, 4'd4, 1'b0);
    expect_out("post_rst_v", 4'd7, 1'b0, 1'b0, 1'b1);

    // Sweep covering propagate-only, generate-heavy and idle cycles.
    for (int i = 0; i < 48; i++) begin
      cyc((i % 5) != 4, B'(i), B'((i * 7 + 3) ^ (i >> 1)), i[0]);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, B'(i), ~B'(i), i[1]);
    end
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
